bcd_char_streamer: RTL
======================

Name: bcd_char_streamer

Overview:
- Downstream consumer of the binary-to-BCD converter's packed BCD result.
- Converts the BCD word into a fixed-width ASCII character stream, most significant digit first, for the on-screen measurement readout (text overlay / character RAM writer).
- Features: leading-zero blanking, optional fixed decimal point, invalid-digit flagging.
- Output uses a valid/ready handshake so the text writer can stall it.

Parameters:
- BCD_DIGITS_PP, 5, number of BCD digits in dat_bcd_i.
- FRAC_DIGITS_PP, 0, digits right of the decimal point; 0 = no point emitted; legal range 0..BCD_DIGITS_PP-1.
- CHAR_COUNT_WIDTH_PP, 4, width of the character index counter; must hold BCD_DIGITS_PP+1.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  capture dat_bcd_i and begin streaming; honoured only when idle.
- dat_bcd_i  input  4*BCD_DIGITS_PP  packed BCD, digit 0 in bits [3:0].
- char_o  output  8  ASCII character.
- char_valid_o  output  1  char_o holds a valid character.
- char_ready_i  input  1  sink accepts char_o this cycle.
- char_last_o  output  1  high with the final character of the field.
- busy_o  output  1  streaming in progress.
- err_o  output  1  sticky: a captured digit was greater than 9.

Behaviour:
- Reset: char_o=8'h20, char_valid_o=0, char_last_o=0, busy_o=0, err_o=0, FSM=IDLE.
- Reset mid-stream aborts the stream immediately; no partial completion.
- FSM states: IDLE, DIGIT, POINT.
  - IDLE: on start_i, capture dat_bcd_i into a shift register, clear err_o, go to DIGIT at the most significant digit. busy_o=1 and char_valid_o=1 from the next cycle (latency 1).
  - DIGIT: present the current digit's character. On transfer (char_valid_o & char_ready_i): advance to the next lower digit. If FRAC_DIGITS_PP>0 and the digit just sent was the least significant integer digit, go to POINT. After the least significant digit, go to IDLE.
  - POINT: present 8'h2E ('.'). On transfer, go to DIGIT at the next lower digit.
- Handshake:
  - char_o and char_last_o are held stable while char_valid_o=1 and char_ready_i=0.
  - char_valid_o never drops without a transfer, except on reset.
  - One character per transfer cycle; char_ready_i held high gives a throughput of 1 char/clk.
- Encoding:
  - Digit d in 0..9 maps to 8'h30+d.
  - Digit above 9 maps to 8'h3F ('?') and sets err_o. err_o is set as the capture is registered and holds until the next accepted start_i or reset.
- Leading-zero blanking:
  - Integer-part zero digits before the first nonzero digit are emitted as 8'h20 (field width stays fixed).
  - The least significant integer digit is never blanked.
  - Fractional digits are never blanked.
  - An invalid digit counts as nonzero and ends blanking.
- Field length: BCD_DIGITS_PP + (FRAC_DIGITS_PP>0 ? 1 : 0) characters. char_last_o is high only with the final character.
- End of stream: the cycle after the last transfer, FSM=IDLE, busy_o=0, char_valid_o=0.
- A start_i asserted in the same cycle as the last transfer is ignored; it must be re-asserted while idle.
- start_i while busy is ignored and the captured data is unchanged.
- dat_bcd_i is sampled only on the accepted start_i cycle.

Decomposition:
- Shared display package:
  - ASCII constants: CHAR_SPACE=8'h20, CHAR_ZERO=8'h30, CHAR_POINT=8'h2E, CHAR_INVALID=8'h3F.
  - FSM state encoding.
- One combinational sub-module, bcd_char_encode:
  - Inputs: 4-bit digit, blank flag.
  - Outputs: 8-bit char, invalid flag.
- FSM, shift register, index counter and blanking flag live in the top module.

Test Plan:
- BCD_DIGITS_PP=5, FRAC=0, dat_bcd_i=20'h00427, start_i pulse, char_ready_i=1 -> chars 20,20,34,32,37 on consecutive cycles; char_last_o with 37; busy_o low the following cycle.
- dat_bcd_i=20'h00000 -> 20,20,20,20,30; err_o=0.
- FRAC=2, dat_bcd_i=20'h00705 -> 20,20,37,2E,30,35; dat_bcd_i=20'h00005 -> 20,20,30,2E,30,35; last on the 6th char.
- Backpressure: dat_bcd_i=20'h12345, char_ready_i random ~50% -> char_o stable during every stall; sequence 31,32,33,34,35; exactly 5 transfers.
- dat_bcd_i=20'h0A012 -> 20,3F,30,31,32; err_o=1 until the next start_i. Then dat_bcd_i=20'h00001 -> err_o=0.
- Two sub-cases:
  - start_i pulsed mid-stream with new data -> ignored; original sequence completes.
  - rst_i after the 2nd transfer -> next cycle char_valid_o=0, busy_o=0; a subsequent start_i streams correctly from the most significant digit.

Source files
------------

// File: rtl/bcd_char_streamer_pkg.sv
// Shared display definitions: ASCII constants, streamer FSM encoding and
// a BCD digit validity helper.
package bcd_char_streamer_pkg;

  localparam logic [7:0] CHAR_SPACE   = 8'h20;
  localparam logic [7:0] CHAR_ZERO    = 8'h30;
  localparam logic [7:0] CHAR_POINT   = 8'h2E;
  localparam logic [7:0] CHAR_INVALID = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_POINT = 2'd2
  } state_e;

  // A BCD nibble is invalid when it encodes a value above 9.
  function automatic logic digit_invalid(input logic [3:0] digit);
    return digit > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_char_encode.sv
// Combinational BCD digit to ASCII encoder with blanking and invalid flag.
module bcd_char_encode
  import bcd_char_streamer_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [7:0] char_o,
  output logic       invalid_o
);

  // Invalid digits always show '?', otherwise blank or '0'+digit.
  always_comb begin
    invalid_o = digit_invalid(digit_i);
    char_o    = CHAR_ZERO + {4'h0, digit_i};
    if (invalid_o) begin
      char_o = CHAR_INVALID;
    end else if (blank_i) begin
      char_o = CHAR_SPACE;
    end
  end

endmodule

// File: rtl/bcd_char_streamer.sv
// Streams a packed BCD word as a fixed-width ASCII field, MSD first, with
// leading-zero blanking, optional decimal point and invalid-digit flag.
module bcd_char_streamer
  import bcd_char_streamer_pkg::*;
#(
  parameter int BCD_DIGITS_PP       = 5,
  parameter int FRAC_DIGITS_PP      = 0,
  parameter int CHAR_COUNT_WIDTH_PP = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [4*BCD_DIGITS_PP-1:0] dat_bcd_i,
  output logic [7:0]                 char_o,
  output logic                       char_valid_o,
  input  logic                       char_ready_i,
  output logic                       char_last_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int SHIFT_W = 4 * BCD_DIGITS_PP;
  localparam logic [CHAR_COUNT_WIDTH_PP-1:0] IDX_LAST =
    CHAR_COUNT_WIDTH_PP'(BCD_DIGITS_PP - 1);
  localparam logic [CHAR_COUNT_WIDTH_PP-1:0] IDX_LSI =
    CHAR_COUNT_WIDTH_PP'(BCD_DIGITS_PP - FRAC_DIGITS_PP - 1);

  state_e                         state_q, state_d;
  logic [SHIFT_W-1:0]             shift_q, shift_d;
  logic [CHAR_COUNT_WIDTH_PP-1:0] idx_q, idx_d;
  logic                           blank_q, blank_d;
  logic                           err_q, err_d;

  logic [3:0] cur_digit;
  logic       cur_blank;
  logic [7:0] enc_char;
  logic       enc_invalid;
  logic       xfer;

  // The digit on display is always the top nibble of the shift register;
  // idx_q tracks its position counted from the most significant digit.
  assign cur_digit = shift_q[SHIFT_W-1 -: 4];
  assign cur_blank = blank_q && (idx_q < IDX_LSI) && (cur_digit == 4'd0);
  assign xfer      = char_valid_o && char_ready_i;

  bcd_char_encode u_encode (
    .digit_i   (cur_digit),
    .blank_i   (cur_blank),
    .char_o    (enc_char),
    .invalid_o (enc_invalid)
  );

  // Outputs decode from registered state, so they hold during a stall.
  always_comb begin
    char_o       = CHAR_SPACE;
    char_valid_o = 1'b0;
    char_last_o  = 1'b0;
    busy_o       = 1'b0;
    err_o        = err_q;
    case (state_q)
      ST_DIGIT: begin
        char_o       = enc_char;
        char_valid_o = 1'b1;
        char_last_o  = (idx_q == IDX_LAST);
        busy_o       = 1'b1;
      end
      ST_POINT: begin
        char_o       = CHAR_POINT;
        char_valid_o = 1'b1;
        busy_o       = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic: capture on start, advance one character per transfer.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    blank_d = blank_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_DIGIT;
          shift_d = dat_bcd_i;
          idx_d   = '0;
          blank_d = 1'b1;
          err_d   = 1'b0;
          for (int unsigned i = 0; i < BCD_DIGITS_PP; i++) begin
            if (digit_invalid(dat_bcd_i[4*i +: 4])) begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_DIGIT: begin
        if (xfer) begin
          shift_d = {shift_q[SHIFT_W-5:0], 4'h0};
          idx_d   = idx_q + CHAR_COUNT_WIDTH_PP'(1);
          if (enc_invalid || (cur_digit != 4'd0)) begin
            blank_d = 1'b0;
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
          end else if ((FRAC_DIGITS_PP > 0) && (idx_q == IDX_LSI)) begin
            state_d = ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (xfer) begin
          state_d = ST_DIGIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      blank_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
      err_q   <= err_d;
    end
  end

endmodule
